// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline fetch/data ports, the arbiter and the shared RAM.
// The arbiter takes the slave view; the pipeline plus RAM side takes the master view.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        stall_f;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        stall_m;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
        output inst_rdata, inst_ready, stall_f, data_rdata, data_ready, stall_m,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
        input  inst_rdata, inst_ready, stall_f, data_rdata, data_ready, stall_m,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch and data memory,
// data first with a starvation guard that forces an instruction grant.
//
// state | meaning
// IDLE  | arbitrate between pending requests, load RAM command registers
// ISSUE | ram_en high for one cycle
// WAIT  | count down remaining RAM read latency
// DONE  | owner ready pulse, read data bypassed then captured
module mem_port_arbiter #(
    parameter int RAM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clka,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAT_INIT   = 3'(RAM_LAT - 1);

    state_t      state_q, state_d;
    logic        owner_data_q, owner_data_d;
    logic        is_read_q, is_read_d;
    logic        ram_en_q, ram_en_d;
    logic [3:0]  ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        inst_ready_q, inst_ready_d;
    logic        data_ready_q, data_ready_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        grant_data;
    logic        finish;
    logic        unused_addr_bits;

    // RAM is word addressed; the byte offset is deliberately dropped.
    assign unused_addr_bits = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

    assign grant_data = bus.data_req & (~bus.inst_req | (starve_cnt_q < STARVE_MAX));

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        is_read_d    = is_read_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 4'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        finish       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.inst_req) starve_cnt_d = 4'd0;
                if (grant_data) begin
                    owner_data_d = 1'b1;
                    is_read_d    = (bus.data_we == 4'b0);
                    ram_en_d     = 1'b1;
                    ram_we_d     = bus.data_we;
                    ram_addr_d   = {bus.data_addr[31:2], 2'b00};
                    ram_wdata_d  = bus.data_wdata;
                    if (bus.inst_req && starve_cnt_q != STARVE_MAX)
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    state_d = ISSUE;
                end else if (bus.inst_req) begin
                    owner_data_d = 1'b0;
                    is_read_d    = 1'b1;
                    ram_en_d     = 1'b1;
                    ram_addr_d   = {bus.inst_addr[31:2], 2'b00};
                    ram_wdata_d  = 32'd0;
                    starve_cnt_d = 4'd0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (!is_read_q || RAM_LAT == 1) begin
                    finish = 1'b1;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q <= 3'd1) begin
                    lat_cnt_d = 3'd0;
                    finish    = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (is_read_q) begin
                    if (owner_data_q) data_rdata_d = bus.ram_rdata;
                    else              inst_rdata_d = bus.ram_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ready is registered, so it is raised on entry to DONE.
        if (finish) begin
            state_d      = DONE;
            inst_ready_d = ~owner_data_q;
            data_ready_d = owner_data_q;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            is_read_q    <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0;
            ram_addr_q   <= 32'd0;
            ram_wdata_q  <= 32'd0;
            lat_cnt_q    <= 3'd0;
            starve_cnt_q <= 4'd0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            is_read_q    <= is_read_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_ready = data_ready_q;
    assign bus.inst_rdata = (state_q == DONE && is_read_q && !owner_data_q) ? bus.ram_rdata : inst_rdata_q;
    assign bus.data_rdata = (state_q == DONE && is_read_q &&  owner_data_q) ? bus.ram_rdata : data_rdata_q;
    assign bus.stall_f    = bus.inst_req & ~inst_ready_q;
    assign bus.stall_m    = bus.data_req & ~data_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (RAM_LAT 1 and 3) with behavioural RAMs; stimulus pushes
// expected RAM commands and completions, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic clka = 1'b0;
    logic rst;
    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int stall_lo = 0;
    int stall_hi = -1;

    mem_port_arbiter_if if1();
    mem_port_arbiter_if if3();

    mem_port_arbiter #(.RAM_LAT(1), .STARVE_LIMIT(4)) u_dut1 (.clka(clka), .rst(rst), .bus(if1));
    mem_port_arbiter #(.RAM_LAT(3), .STARVE_LIMIT(4)) u_dut3 (.clka(clka), .rst(rst), .bus(if3));

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] r1_s0, r3_s0, r3_s1, r3_s2;

    always @(posedge clka) begin
        if (if1.ram_en === 1'b1) begin
            r1_s0 <= mem1[if1.ram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (if1.ram_we[b]) mem1[if1.ram_addr[9:2]][8*b +: 8] = if1.ram_wdata[8*b +: 8];
        end
    end
    assign if1.ram_rdata = r1_s0;

    always @(posedge clka) begin
        if (if3.ram_en === 1'b1) begin
            r3_s0 <= mem3[if3.ram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (if3.ram_we[b]) mem3[if3.ram_addr[9:2]][8*b +: 8] = if3.ram_wdata[8*b +: 8];
        end
        r3_s1 <= r3_s0;
        r3_s2 <= r3_s1;
    end
    assign if3.ram_rdata = r3_s2;

    typedef struct { logic [31:0] addr; logic [3:0] we; logic [31:0] wdata; int at; } cmd_t;
    typedef struct { logic rd; logic [31:0] data; int at; } rsp_t;

    cmd_t cmd1_q[$], cmd3_q[$];
    rsp_t ir1_q[$], dr1_q[$], ir3_q[$], dr3_q[$];

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, exp, cyc);
        end
    endfunction

    function automatic void cmp_cmd(string nm, bit have, cmd_t e, logic [3:0] we,
                                    logic [31:0] addr, logic [31:0] wd);
        n_chk++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: unexpected ram_en at cycle %0d addr=%h we=%b", nm, cyc, addr, we);
        end else if (we !== e.we || addr !== e.addr || (e.we != 4'b0 && wd !== e.wdata) || cyc != e.at) begin
            n_fail++;
            $display("FAIL %s: got we=%b addr=%h wdata=%h cycle=%0d, required we=%b addr=%h wdata=%h cycle=%0d",
                     nm, we, addr, wd, cyc, e.we, e.addr, e.wdata, e.at);
        end
    endfunction

    function automatic void cmp_rsp(string nm, bit have, rsp_t e, logic [31:0] got);
        n_chk++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s: unexpected ready at cycle %0d rdata=%h", nm, cyc, got);
        end else if (cyc != e.at || (e.rd && got !== e.data)) begin
            n_fail++;
            $display("FAIL %s: got rdata=%h cycle=%0d, required rdata=%h cycle=%0d", nm, got, cyc, e.data, e.at);
        end
    endfunction

    always @(negedge clka) begin : mon1
        cmd_t c;
        rsp_t r;
        bit   h;
        if (if1.ram_en === 1'b1) begin
            c = '{addr: 0, we: 0, wdata: 0, at: 0};
            h = cmd1_q.size() > 0;
            if (h) c = cmd1_q.pop_front();
            cmp_cmd("dut1_cmd", h, c, if1.ram_we, if1.ram_addr, if1.ram_wdata);
        end
        if (if1.inst_ready === 1'b1) begin
            r = '{rd: 0, data: 0, at: 0};
            h = ir1_q.size() > 0;
            if (h) r = ir1_q.pop_front();
            cmp_rsp("dut1_inst", h, r, if1.inst_rdata);
        end
        if (if1.data_ready === 1'b1) begin
            r = '{rd: 0, data: 0, at: 0};
            h = dr1_q.size() > 0;
            if (h) r = dr1_q.pop_front();
            cmp_rsp("dut1_data", h, r, if1.data_rdata);
        end
    end

    always @(negedge clka) begin : mon3
        cmd_t c;
        rsp_t r;
        bit   h;
        if (if3.ram_en === 1'b1) begin
            c = '{addr: 0, we: 0, wdata: 0, at: 0};
            h = cmd3_q.size() > 0;
            if (h) c = cmd3_q.pop_front();
            cmp_cmd("dut3_cmd", h, c, if3.ram_we, if3.ram_addr, if3.ram_wdata);
        end
        if (if3.inst_ready === 1'b1) begin
            r = '{rd: 0, data: 0, at: 0};
            h = ir3_q.size() > 0;
            if (h) r = ir3_q.pop_front();
            cmp_rsp("dut3_inst", h, r, if3.inst_rdata);
        end
        if (if3.data_ready === 1'b1) begin
            r = '{rd: 0, data: 0, at: 0};
            h = dr3_q.size() > 0;
            if (h) r = dr3_q.pop_front();
            cmp_rsp("dut3_data", h, r, if3.data_rdata);
        end
    end

    // Holds requests until the matching ready pulse, then drops them in the following IDLE cycle.
    task automatic run(input bit d3, input int max_cyc, input bit hold_data);
        bit ri, rd, ireq, dreq;
        int n;
        n = 0;
        forever begin
            ireq = d3 ? if3.inst_req : if1.inst_req;
            dreq = d3 ? if3.data_req : if1.data_req;
            if (!(ireq || (dreq && !hold_data))) break;
            if (n >= max_cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL run_timeout: dut%0d still requesting after %0d cycles", d3 ? 3 : 1, n);
                if (d3) begin if3.inst_req = 1'b0; if3.data_req = 1'b0; end
                else    begin if1.inst_req = 1'b0; if1.data_req = 1'b0; end
                break;
            end
            @(negedge clka);
            ri = d3 ? if3.inst_ready : if1.inst_ready;
            rd = d3 ? if3.data_ready : if1.data_ready;
            if (!d3 && cyc >= stall_lo && cyc <= stall_hi) chk("stall_f_held", 32'(if1.stall_f), 32'd1);
            @(posedge clka);
            #1;
            if (ri) begin
                if (d3) if3.inst_req = 1'b0; else if1.inst_req = 1'b0;
            end
            if (rd && !hold_data) begin
                if (d3) if3.data_req = 1'b0; else if1.data_req = 1'b0;
            end
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = {16'hF00D, 8'h00, 8'(i)};
            mem3[i] = {16'hBEAD, 8'h00, 8'(i)};
        end
        mem1[0]   = 32'hA0A0_0000;
        mem1[16]  = 32'hA0A0_0040;
        mem1[17]  = 32'hA0A0_0044;
        mem1[64]  = 32'h1111_2222;
        mem1[192] = 32'h3333_0300;
        mem3[0]   = 32'hC0DE_0000;
        mem3[16]  = 32'hCAFE_0040;
        mem3[128] = 32'h1234_5678;

        if1.inst_req = 0; if1.inst_addr = 0; if1.data_req = 0; if1.data_we = 0;
        if1.data_addr = 0; if1.data_wdata = 0;
        if3.inst_req = 0; if3.inst_addr = 0; if3.data_req = 0; if3.data_we = 0;
        if3.data_addr = 0; if3.data_wdata = 0;
        rst = 1'b1;
        repeat (3) @(posedge clka);
        #1 rst = 1'b0;

        // Reset state: everything quiet for three cycles
        repeat (3) begin
            @(negedge clka);
            chk("idle_outs_dut1", 32'({if1.inst_ready, if1.data_ready, if1.stall_f, if1.stall_m, if1.ram_en,
                |if1.ram_we, |if1.ram_addr, |if1.ram_wdata, |if1.inst_rdata, |if1.data_rdata}), 32'd0);
            chk("idle_outs_dut3", 32'({if3.inst_ready, if3.data_ready, if3.stall_f, if3.stall_m, if3.ram_en,
                |if3.ram_we, |if3.ram_addr, |if3.ram_wdata, |if3.inst_rdata, |if3.data_rdata}), 32'd0);
        end

        // Single instruction fetch, RAM_LAT=1
        @(posedge clka); #1; t0 = cyc;
        if1.inst_req = 1; if1.inst_addr = 32'h40;
        cmd1_q.push_back('{addr: 32'h40, we: 4'b0, wdata: 0, at: t0 + 1});
        ir1_q.push_back('{rd: 1, data: 32'hA0A0_0040, at: t0 + 2});
        run(0, 20, 0);

        // Simultaneous data write and instruction fetch
        @(posedge clka); #1; t0 = cyc;
        if1.data_req = 1; if1.data_we = 4'b0011; if1.data_addr = 32'h100; if1.data_wdata = 32'hDEAD_BEEF;
        if1.inst_req = 1; if1.inst_addr = 32'h0;
        cmd1_q.push_back('{addr: 32'h100, we: 4'b0011, wdata: 32'hDEAD_BEEF, at: t0 + 1});
        cmd1_q.push_back('{addr: 32'h0, we: 4'b0, wdata: 0, at: t0 + 4});
        dr1_q.push_back('{rd: 0, data: 0, at: t0 + 2});
        ir1_q.push_back('{rd: 1, data: 32'hA0A0_0000, at: t0 + 5});
        stall_lo = t0; stall_hi = t0 + 4;
        run(0, 30, 0);
        stall_hi = -1;

        // Starvation guard: four data grants, one forced fetch, then data again
        @(posedge clka); #1; t0 = cyc;
        if1.data_req = 1; if1.data_we = 4'b0; if1.data_addr = 32'h300;
        if1.inst_req = 1; if1.inst_addr = 32'h44;
        for (int k = 0; k < 4; k++) begin
            cmd1_q.push_back('{addr: 32'h300, we: 4'b0, wdata: 0, at: t0 + 1 + 3*k});
            dr1_q.push_back('{rd: 1, data: 32'h3333_0300, at: t0 + 2 + 3*k});
        end
        cmd1_q.push_back('{addr: 32'h44, we: 4'b0, wdata: 0, at: t0 + 13});
        ir1_q.push_back('{rd: 1, data: 32'hA0A0_0044, at: t0 + 14});
        cmd1_q.push_back('{addr: 32'h300, we: 4'b0, wdata: 0, at: t0 + 16});
        dr1_q.push_back('{rd: 1, data: 32'h3333_0300, at: t0 + 17});
        run(0, 40, 1);
        run(0, 20, 0);

        // Unaligned data read returns the word including the earlier byte-masked write
        @(posedge clka); #1; t0 = cyc;
        if1.data_req = 1; if1.data_we = 4'b0; if1.data_addr = 32'h103;
        cmd1_q.push_back('{addr: 32'h100, we: 4'b0, wdata: 0, at: t0 + 1});
        dr1_q.push_back('{rd: 1, data: 32'h1111_BEEF, at: t0 + 2});
        run(0, 20, 0);

        // RAM_LAT=3 data read, result held after request drops
        @(posedge clka); #1; t0 = cyc;
        if3.data_req = 1; if3.data_we = 4'b0; if3.data_addr = 32'h200;
        cmd3_q.push_back('{addr: 32'h200, we: 4'b0, wdata: 0, at: t0 + 1});
        dr3_q.push_back('{rd: 1, data: 32'h1234_5678, at: t0 + 4});
        run(1, 20, 0);
        repeat (2) @(negedge clka);
        chk("dut3_data_rdata_hold", if3.data_rdata, 32'h1234_5678);

        // Instruction fetch on RAM_LAT=3 so the later reset has something to clear
        @(posedge clka); #1; t0 = cyc;
        if3.inst_req = 1; if3.inst_addr = 32'h0;
        cmd3_q.push_back('{addr: 32'h0, we: 4'b0, wdata: 0, at: t0 + 1});
        ir3_q.push_back('{rd: 1, data: 32'hC0DE_0000, at: t0 + 4});
        run(1, 20, 0);

        // Reset during WAIT of an instruction read
        @(posedge clka); #1; t0 = cyc;
        if3.inst_req = 1; if3.inst_addr = 32'h40;
        cmd3_q.push_back('{addr: 32'h40, we: 4'b0, wdata: 0, at: t0 + 1});
        @(posedge clka); #1;
        @(posedge clka); #1;
        rst = 1'b1; if3.inst_req = 0;
        @(posedge clka); #1;
        rst = 1'b0;
        chk("rst_inst_ready", 32'(if3.inst_ready), 32'd0);
        chk("rst_inst_rdata", if3.inst_rdata, 32'd0);
        chk("rst_data_rdata", if3.data_rdata, 32'd0);
        chk("rst_ram_en", 32'(if3.ram_en), 32'd0);
        repeat (4) @(posedge clka);

        // Fresh request after reset completes normally
        #1; t0 = cyc;
        if3.inst_req = 1; if3.inst_addr = 32'h40;
        cmd3_q.push_back('{addr: 32'h40, we: 4'b0, wdata: 0, at: t0 + 1});
        ir3_q.push_back('{rd: 1, data: 32'hCAFE_0040, at: t0 + 4});
        run(1, 20, 0);

        repeat (3) @(posedge clka);
        chk("pending_cmd1", 32'(cmd1_q.size()), 32'd0);
        chk("pending_cmd3", 32'(cmd3_q.size()), 32'd0);
        chk("pending_inst1", 32'(ir1_q.size()), 32'd0);
        chk("pending_data1", 32'(dr1_q.size()), 32'd0);
        chk("pending_inst3", 32'(ir3_q.size()), 32'd0);
        chk("pending_data3", 32'(dr3_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one synchronous single-port RAM between the pipeline's instruction-fetch port and data-memory port. It sits between `mips` and the memory, replacing separate instruction and data RAMs. It serialises requests with data-over-instruction priority and a starvation guard, and issues registered RAM commands. It returns per-port ready pulses and stall levels that the pipeline uses to freeze F or M.

## Interface
Parameters:
- RAM_LAT, 1, RAM read latency in cycles from `ram_en` to valid `ram_rdata` (legal 1..4)
- STARVE_LIMIT, 4, consecutive data grants allowed while `inst_req` is pending before instruction is forced (legal 1..15)

Ports:
- clka  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request, level, held until `inst_ready`
- inst_addr  in  32  fetch byte address
- inst_rdata  out  32  fetched word, valid when `inst_ready`=1, held until next `inst_ready`
- inst_ready  out  1  one-cycle completion pulse
- stall_f  out  1  `inst_req & ~inst_ready`
- data_req  in  1  data request, level, held until `data_ready`
- data_we  in  4  byte write enables, 0 = read
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_rdata  out  32  read word, valid when `data_ready`=1 on a read, held until next read completion
- data_ready  out  1  one-cycle completion pulse
- stall_m  out  1  `data_req & ~data_ready`
- ram_en  out  1  RAM access strobe, registered
- ram_we  out  4  RAM byte write enables, registered
- ram_addr  out  32  RAM byte address, registered; `addr[1:0]` forced to 0
- ram_wdata  out  32  RAM write data, registered
- ram_rdata  in  32  RAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrates among the current requests.
  - If `data_req`=1 and (`inst_req`=0 or starve_cnt < STARVE_LIMIT), grant data.
  - Otherwise, if `inst_req`=1, grant instruction.
  - On grant: latch owner, address, we and wdata, then go to ISSUE.
- ISSUE, one cycle:
  - `ram_en`=1; `ram_we`=latched we (instruction grant: 0).
  - On a write, go to DONE.
  - On a read with RAM_LAT=1, go to DONE; otherwise go to WAIT with lat_cnt=RAM_LAT-1.
- WAIT: decrement lat_cnt each cycle; go to DONE when lat_cnt reaches 1.
- DONE, one cycle:
  - Pulse the owner's ready.
  - On a read, capture `ram_rdata` into the owner's rdata register, visible in the same cycle via bypass.
  - Return to IDLE.
- The completing port's request is not sampled in DONE. A request still high in the following IDLE cycle is treated as a new transaction.
- starve_cnt:
  - Increments on each data grant made while `inst_req`=1, saturating at STARVE_LIMIT.
  - Clears on every instruction grant, and on any IDLE cycle with `inst_req`=0.
- Request inputs change only when their port is idle or in its DONE cycle. Address, we and wdata changes after grant are ignored.
- Reset, including mid-transaction:
  - state=IDLE; `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - Both ready outputs 0, both rdata registers 0; starve_cnt=0, lat_cnt=0.
  - An in-flight read result is discarded and no ready pulse is emitted for it.

## Timing
- Read latency: request seen in IDLE at cycle 0, then ISSUE at cycle 1, then ready at cycle 1+RAM_LAT.
- Write latency: ready at cycle 2.
- Back-to-back reads from one port: one completion every RAM_LAT+2 cycles.
- Alternating ports: same rate, since arbitration always occurs in IDLE.
- Both requests arriving in the same cycle: data is granted first; instruction is granted at the next IDLE.
- Stall outputs are combinational from req and ready. All other outputs are registered, except the rdata bypass in DONE.
- `ram_en` is high for exactly one cycle per transaction and never in IDLE, WAIT or DONE.

## Test plan
1. Reset, then idle. Required:
   - All outputs 0 for 3 cycles.
   - `inst_req`=1, `inst_addr`=0x00000040 gives `ram_en`=1 with `ram_addr`=0x40 at cycle 1.
   - With RAM_LAT=1: `inst_ready`=1 and `inst_rdata`=RAM word at cycle 2.
2. Simultaneous requests: data write `data_we`=4'b0011 to 0x100 (`data_wdata`=0xDEADBEEF) plus instruction read of 0x0. Required:
   - Data issues first with `ram_we`=0011; `data_ready` at cycle 2.
   - Instruction issues at cycle 4; `inst_ready` at cycle 5.
   - `stall_f`=1 throughout cycles 0-4.
3. Starvation with STARVE_LIMIT=4: `data_req` held high continuously and `inst_req` high. Required: exactly 4 data grants, then 1 instruction grant, then data again; `inst_ready` is never missing for more than 4 data transactions.
4. RAM_LAT=3, a data read of 0x200 returning 0x12345678. Required:
   - `ram_en` pulses once.
   - `data_ready` 3 cycles after ISSUE, with `data_rdata`=0x12345678, held after `data_req` drops.
5. Reset asserted during WAIT of an instruction read. Required:
   - Next cycle: state IDLE, no `inst_ready` pulse, `inst_rdata`=0.
   - A fresh request afterwards completes normally.
6. Address `data_addr`=0x103 on a read. Required: `ram_addr`=0x100.
